// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and helpers for the memory-cycle sequencer
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DROP,
        FIN
    } state_t;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int NBW = 4;

    // Bits needed to count 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((v - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// rtl/mem_timeout.sv - answer-timeout up-counter with clear, enable and terminal count
module mem_timeout
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = clog2(TIMEOUT)
) (
    input  logic clk_sys,
    input  logic rst_,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at the terminal count so a stalled enable cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_cycle.sv
// rtl/mem_cycle.sv - four-phase memory bus cycle sequencer; MEM_RETRY_EN adds one retry on pe
module mem_cycle
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic           clk_sys,
    input  logic           rst_,
    input  logic           start_rd,
    input  logic           start_wr,
    input  logic [AW-1:0]  dad_,
    input  logic [DW-1:0]  ddt_,
    input  logic [NBW-1:0] nb,
    output logic           req,
    output logic           w,
    output logic           r,
    output logic [AW-1:0]  ad,
    output logic [DW-1:0]  dt_out,
    output logic [NBW-1:0] nb_out,
    input  logic           ok,
    input  logic           pe,
    input  logic [DW-1:0]  dt_in,
    output logic [DW-1:0]  rdt_,
    output logic           busy,
    output logic           done,
    output logic           alarm,
    output logic           perr
);

    state_t         state_q, state_d;
    logic           ok_q, pe_q;
    logic [DW-1:0]  dt_in_q;
    logic           req_q, req_d, w_q, w_d, r_q, r_d;
    logic [AW-1:0]  ad_q, ad_d;
    logic [DW-1:0]  dt_out_q, dt_out_d;
    logic [NBW-1:0] nb_out_q, nb_out_d;
    logic [DW-1:0]  rdt_q, rdt_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           alarm_q, alarm_d, perr_q, perr_d;
    logic           is_wr_q, is_wr_d;
    logic           alarm_pend_q, alarm_pend_d, perr_pend_q, perr_pend_d;
    logic           tmo_clr, tmo_en, tmo_tc;
`ifdef MEM_RETRY_EN
    logic           retry_q, retry_d, reissue_q, reissue_d;
`endif

    mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_sys (clk_sys),
        .rst_    (rst_),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .tc      (tmo_tc)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        w_d          = w_q;
        r_d          = r_q;
        ad_d         = ad_q;
        dt_out_d     = dt_out_q;
        nb_out_d     = nb_out_q;
        rdt_d        = rdt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        alarm_d      = 1'b0;
        perr_d       = 1'b0;
        is_wr_d      = is_wr_q;
        alarm_pend_d = alarm_pend_q;
        perr_pend_d  = perr_pend_q;
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;
`ifdef MEM_RETRY_EN
        retry_d      = retry_q;
        reissue_d    = reissue_q;
`endif
        case (state_q)
            IDLE: begin
                // done_q high means busy dropped this cycle; that start is refused.
                if ((start_rd || start_wr) && !done_q) begin
                    ad_d         = ~dad_;
                    nb_out_d     = nb;
                    if (start_wr) begin
                        dt_out_d = ~ddt_;
                    end
                    is_wr_d      = start_wr;
                    req_d        = 1'b1;
                    w_d          = start_wr;
                    r_d          = !start_wr;
                    busy_d       = 1'b1;
                    alarm_pend_d = 1'b0;
                    perr_pend_d  = 1'b0;
                    tmo_clr      = 1'b1;
`ifdef MEM_RETRY_EN
                    retry_d      = 1'b0;
                    reissue_d    = 1'b0;
`endif
                    state_d      = REQ;
                end
            end
            REQ: begin
                tmo_en = 1'b1;
                if (pe_q) begin
                    req_d   = 1'b0;
                    w_d     = 1'b0;
                    r_d     = 1'b0;
                    state_d = WAIT_DROP;
`ifdef MEM_RETRY_EN
                    if (!retry_q) begin
                        retry_d   = 1'b1;
                        reissue_d = 1'b1;
                    end else begin
                        perr_pend_d = 1'b1;
                    end
`else
                    perr_pend_d = 1'b1;
`endif
                end else if (ok_q) begin
                    if (!is_wr_q) begin
                        rdt_d = ~dt_in_q;
                    end
                    req_d   = 1'b0;
                    w_d     = 1'b0;
                    r_d     = 1'b0;
                    state_d = WAIT_DROP;
                end else if (tmo_tc) begin
                    req_d        = 1'b0;
                    w_d          = 1'b0;
                    r_d          = 1'b0;
                    alarm_pend_d = 1'b1;
                    state_d      = FIN;
                end
            end
            WAIT_DROP: begin
                if (!ok_q && !pe_q) begin
`ifdef MEM_RETRY_EN
                    if (reissue_q) begin
                        reissue_d = 1'b0;
                        req_d     = 1'b1;
                        w_d       = is_wr_q;
                        r_d       = !is_wr_q;
                        tmo_clr   = 1'b1;
                        state_d   = REQ;
                    end else begin
                        state_d = FIN;
                    end
`else
                    state_d = FIN;
`endif
                end
            end
            FIN: begin
                done_d  = 1'b1;
                alarm_d = alarm_pend_q;
                perr_d  = perr_pend_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            ok_q         <= 1'b0;
            pe_q         <= 1'b0;
            dt_in_q      <= '0;
            req_q        <= 1'b0;
            w_q          <= 1'b0;
            r_q          <= 1'b0;
            ad_q         <= '0;
            dt_out_q     <= '0;
            nb_out_q     <= '0;
            rdt_q        <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            alarm_q      <= 1'b0;
            perr_q       <= 1'b0;
            is_wr_q      <= 1'b0;
            alarm_pend_q <= 1'b0;
            perr_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ok_q         <= ok;
            pe_q         <= pe;
            dt_in_q      <= dt_in;
            req_q        <= req_d;
            w_q          <= w_d;
            r_q          <= r_d;
            ad_q         <= ad_d;
            dt_out_q     <= dt_out_d;
            nb_out_q     <= nb_out_d;
            rdt_q        <= rdt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            alarm_q      <= alarm_d;
            perr_q       <= perr_d;
            is_wr_q      <= is_wr_d;
            alarm_pend_q <= alarm_pend_d;
            perr_pend_q  <= perr_pend_d;
        end
    end

`ifdef MEM_RETRY_EN
    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            retry_q   <= 1'b0;
            reissue_q <= 1'b0;
        end else begin
            retry_q   <= retry_d;
            reissue_q <= reissue_d;
        end
    end
`endif

    assign req    = req_q;
    assign w      = w_q;
    assign r      = r_q;
    assign ad     = ad_q;
    assign dt_out = dt_out_q;
    assign nb_out = nb_out_q;
    assign rdt_   = rdt_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign alarm  = alarm_q;
    assign perr   = perr_q;

endmodule

// File: tb/tb_mem_cycle.sv
// tb/tb_mem_cycle.sv - directed self-checking bench for mem_cycle with a four-phase bus responder
module tb_mem_cycle;

    localparam int M_NONE  = 0;
    localparam int M_OK    = 1;
    localparam int M_PE    = 2;
    localparam int M_PE_OK = 3;

    logic        clk_sys, rst_;
    logic        start_rd, start_wr;
    logic [15:0] dad_, ddt_;
    logic [3:0]  nb;
    logic        req, w, r;
    logic [15:0] ad, dt_out, nb_out_w;
    logic [3:0]  nb_out;
    logic        ok, pe;
    logic        ok_m, pe_m, stray_ok;
    logic [15:0] dt_in;
    logic [15:0] rdt_;
    logic        busy, done, alarm, perr;

    int bus_mode, bus_delay, test_id;
    logic [15:0] bus_data;
    int req_rises, req_high;
    int n_tests, n_fail;

    assign ok = ok_m | stray_ok;
    assign pe = pe_m;
    assign nb_out_w = {12'h000, nb_out};

    mem_cycle #(.TIMEOUT(8)) dut (
        .clk_sys  (clk_sys),
        .rst_     (rst_),
        .start_rd (start_rd),
        .start_wr (start_wr),
        .dad_     (dad_),
        .ddt_     (ddt_),
        .nb       (nb),
        .req      (req),
        .w        (w),
        .r        (r),
        .ad       (ad),
        .dt_out   (dt_out),
        .nb_out   (nb_out),
        .ok       (ok),
        .pe       (pe),
        .dt_in    (dt_in),
        .rdt_     (rdt_),
        .busy     (busy),
        .done     (done),
        .alarm    (alarm),
        .perr     (perr)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Bus responder: answers after bus_delay req-high cycles, holds until req drops.
    initial begin
        logic req_prev, answering;
        int   rcnt, ans_count, last_id;
        ok_m = 1'b0; pe_m = 1'b0; dt_in = '0;
        req_rises = 0; req_high = 0;
        req_prev = 1'b0; answering = 1'b0; rcnt = 0; ans_count = 0; last_id = -1;
        forever begin
            @(negedge clk_sys);
            if (test_id != last_id) begin
                ans_count = 0;
                last_id   = test_id;
            end
            if (req) begin
                if (!req_prev) begin
                    req_rises = req_rises + 1;
                    rcnt      = 0;
                end
                req_high = req_high + 1;
                rcnt     = rcnt + 1;
                if (!answering && bus_mode != M_NONE && rcnt == bus_delay) begin
                    answering = 1'b1;
                    if (bus_mode == M_PE || (bus_mode == M_PE_OK && ans_count == 0)) begin
                        pe_m = 1'b1;
                    end else begin
                        ok_m = 1'b1;
                    end
                    dt_in     = bus_data;
                    ans_count = ans_count + 1;
                end
            end else begin
                ok_m = 1'b0; pe_m = 1'b0; answering = 1'b0; rcnt = 0;
            end
            req_prev = req;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [3:0] n);
        start_rd = rd; start_wr = wr; dad_ = a; ddt_ = d; nb = n;
        step();
        start_rd = 1'b0; start_wr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic setup_bus(input int mode, input int dly, input logic [15:0] data);
        bus_mode  = mode;
        bus_delay = dly;
        bus_data  = data;
        test_id   = test_id + 1;
    endtask

    initial begin
        int r0, h0, dcount;
        n_tests = 0; n_fail = 0; test_id = 0;
        bus_mode = M_NONE; bus_delay = 1; bus_data = '0; stray_ok = 1'b0;
        rst_ = 1'b0; start_rd = 1'b0; start_wr = 1'b0; dad_ = '1; ddt_ = '1; nb = '0;
        step(); step();
        check("rst_req",   {31'd0, req},  32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_ad",    {16'd0, ad},   32'h0);
        check("rst_rdt",   {16'd0, rdt_}, 32'hFFFF);
        rst_ = 1'b1;
        step();

        // Read: answer on the bus in the 3rd req cycle, req low 2 cycles later.
        setup_bus(M_OK, 3, 16'h1234);
        r0 = req_rises;
        start(1'b1, 1'b0, 16'hEDCB, 16'h0000, 4'd3);
        check("rd_req",    {31'd0, req},  32'd1);
        check("rd_r",      {31'd0, r},    32'd1);
        check("rd_w",      {31'd0, w},    32'd0);
        check("rd_busy",   {31'd0, busy}, 32'd1);
        check("rd_ad",     {16'd0, ad},   32'h1234);
        check("rd_nb",     {16'd0, nb_out_w}, 32'd3);
        step(); step(); step();
        check("rd_req_c4", {31'd0, req},  32'd1);
        step();
        check("rd_req_c5", {31'd0, req},  32'd0);
        check("rd_rdt",    {16'd0, rdt_}, 32'hEDCB);
        wait_done("rd");
        check("rd_alarm",  {31'd0, alarm}, 32'd0);
        check("rd_perr",   {31'd0, perr},  32'd0);
        check("rd_busy_end", {31'd0, busy}, 32'd0);
        // A start in the cycle busy drops is refused.
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        check("rd_done_pulse", {31'd0, done}, 32'd0);
        check("late_start_req", {31'd0, req}, 32'd0);
        check("rd_rises",  req_rises - r0, 32'd1);
        step();

        // Write.
        setup_bus(M_OK, 2, 16'h0000);
        start(1'b0, 1'b1, 16'hFFFE, 16'h00FF, 4'd5);
        check("wr_ad",     {16'd0, ad},     32'h0001);
        check("wr_dt",     {16'd0, dt_out}, 32'hFF00);
        check("wr_w",      {31'd0, w},      32'd1);
        check("wr_r",      {31'd0, r},      32'd0);
        check("wr_nb",     {16'd0, nb_out_w}, 32'd5);
        wait_done("wr");
        check("wr_ok_low", {31'd0, ok},     32'd0);
        check("wr_rdt",    {16'd0, rdt_},   32'hEDCB);
        check("wr_perr",   {31'd0, perr},   32'd0);
        step();

        // Timeout on a silent bus.
        setup_bus(M_NONE, 1, 16'h0000);
        h0 = req_high;
        start(1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        wait_done("to");
        check("to_alarm",  {31'd0, alarm}, 32'd1);
        check("to_perr",   {31'd0, perr},  32'd0);
        check("to_busy",   {31'd0, busy},  32'd0);
        check("to_req_high", req_high - h0, 32'd8);
        step();
        check("to_alarm_pulse", {31'd0, alarm}, 32'd0);
        stray_ok = 1'b1;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) stray_ok = 1'b0;
            if (done || busy || req) dcount++;
        end
        check("to_stray_ok", dcount, 32'd0);
        check("to_rdt",    {16'd0, rdt_}, 32'hEDCB);

        // pe on every attempt.
        setup_bus(M_PE, 2, 16'hABCD);
        r0 = req_rises;
        start(1'b1, 1'b0, 16'h1111, 16'h0000, 4'd1);
        wait_done("pe");
        check("pe_perr",   {31'd0, perr},  32'd1);
        check("pe_alarm",  {31'd0, alarm}, 32'd0);
        check("pe_rdt",    {16'd0, rdt_},  32'hEDCB);
`ifdef MEM_RETRY_EN
        check("pe_rises",  req_rises - r0, 32'd2);
`else
        check("pe_rises",  req_rises - r0, 32'd1);
`endif
        step(); step();

        // pe then ok.
        setup_bus(M_PE_OK, 2, 16'hABCD);
        r0 = req_rises;
        start(1'b1, 1'b0, 16'h1111, 16'h0000, 4'd1);
        wait_done("peok");
`ifdef MEM_RETRY_EN
        check("peok_perr",  {31'd0, perr},  32'd0);
        check("peok_rdt",   {16'd0, rdt_},  32'h5432);
        check("peok_rises", req_rises - r0, 32'd2);
`else
        check("peok_perr",  {31'd0, perr},  32'd1);
        check("peok_rdt",   {16'd0, rdt_},  32'hEDCB);
        check("peok_rises", req_rises - r0, 32'd1);
`endif
        step(); step();

        // Start while busy is ignored.
        setup_bus(M_OK, 3, 16'h0F0F);
        r0 = req_rises;
        start(1'b1, 1'b0, 16'hAAAA, 16'h0000, 4'd2);
        step();
        start(1'b1, 1'b0, 16'h5555, 16'h0000, 4'd9);
        check("busy_ad",   {16'd0, ad},       32'h5555);
        check("busy_nb",   {16'd0, nb_out_w}, 32'd2);
        wait_done("busy");
        check("busy_rdt",  {16'd0, rdt_},     32'hF0F0);
        step(); step();
        check("busy_rises", req_rises - r0,   32'd1);

        // Simultaneous start_rd and start_wr is a write.
        setup_bus(M_OK, 2, 16'h7777);
        start(1'b1, 1'b1, 16'h0000, 16'h1234, 4'd4);
        check("both_w",    {31'd0, w},      32'd1);
        check("both_r",    {31'd0, r},      32'd0);
        check("both_dt",   {16'd0, dt_out}, 32'hEDCB);
        wait_done("both");
        check("both_rdt",  {16'd0, rdt_},   32'hF0F0);
        step(); step();

        // Reset in REQ.
        setup_bus(M_NONE, 1, 16'h0000);
        start(1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        step();
        check("mrst_req_before", {31'd0, req}, 32'd1);
        rst_ = 1'b0;
        #1;
        check("mrst_req",  {31'd0, req},  32'd0);
        check("mrst_rdt",  {16'd0, rdt_}, 32'hFFFF);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        step();
        rst_ = 1'b1;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || req) dcount++;
        end
        check("mrst_no_done", dcount, 32'd0);
        setup_bus(M_OK, 1, 16'h00AA);
        start(1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        wait_done("post");
        check("post_rdt",  {16'd0, rdt_},  32'hFF55);
        check("post_alarm", {31'd0, alarm}, 32'd0);
        check("post_perr", {31'd0, perr},  32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_cycle.md
Name: mem_cycle

Overview:
- Memory-cycle sequencer directly downstream of the P-A unit.
- Consumes the active-low address (dad_) and data (ddt_) buses that P-A drives.
- Runs one read or write cycle on the system memory bus using a four-phase req/answer handshake with a no-answer timeout.
- On read, returns the fetched word to P-A as active-low rdt_, held stable until the next cycle.

Parameters:
- TIMEOUT, 64, clock cycles to wait for an answer after req rises before declaring no-answer (legal range 2..255).

Ports:
- clk_sys  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- start_rd  in  1  single-cycle pulse: begin read cycle
- start_wr  in  1  single-cycle pulse: begin write cycle
- dad_  in  16  address from P-A, active-low, sampled at start
- ddt_  in  16  write data from P-A, active-low, sampled at start
- nb  in  4  memory block number, sampled at start
- req  out  1  bus request
- w  out  1  bus write strobe, qualifies req
- r  out  1  bus read strobe, qualifies req
- ad  out  16  bus address, active-high
- dt_out  out  16  bus write data, active-high
- nb_out  out  4  bus block number
- ok  in  1  bus answer: cycle accepted
- pe  in  1  bus answer: parity error
- dt_in  in  16  bus read data, valid while ok=1
- rdt_  out  16  read data to P-A, active-low
- busy  out  1  cycle in progress
- done  out  1  one-cycle pulse, cycle finished (any outcome)
- alarm  out  1  one-cycle pulse, no answer within TIMEOUT
- perr  out  1  one-cycle pulse, pe answer received

Behaviour:
- Reset values:
  - req, w, r, busy, done, alarm, perr = 0.
  - ad, dt_out, nb_out = 0.
  - rdt_ = 16'hFFFF (all ones, i.e. data zero).
- All inputs from the bus are registered once before use (1-cycle synchroniser). All outputs are registered.
- States: IDLE, REQ, WAIT_DROP, FIN.
- IDLE:
  - On start_rd or start_wr: latch ad=~dad_, dt_out=~ddt_ (write only), nb_out=nb.
  - Next cycle: assert busy, req, and r or w; go to REQ.
  - start_rd and start_wr together: treated as write; r stays 0.
  - Starts while busy=1 are ignored, with no queueing.
- REQ:
  - Timeout counter clears on entry and increments every cycle.
  - Registered ok=1: on read, capture rdt_ <= ~dt_in in that cycle. Drop req/r/w next cycle; go to WAIT_DROP.
  - Registered pe=1: drop req/r/w; set perr pending; go to WAIT_DROP. rdt_ is not updated.
  - ok and pe both 1: pe wins.
  - Counter reaches TIMEOUT-1 with no answer: drop req/r/w; set alarm pending; go directly to FIN.
  - Answer arriving in the same cycle the counter reaches TIMEOUT-1 counts as an answer, not a timeout.
- WAIT_DROP:
  - Wait for registered ok=0 and pe=0 (four-phase completion), then go to FIN.
  - No timeout in this state.
- FIN:
  - Pulse done for 1 cycle, plus alarm or perr if pending.
  - Clear busy; go to IDLE.
  - A new start may arrive in the same cycle busy drops and is ignored. It is accepted from the following cycle.
- Latency: start pulse to req = 1 cycle. Answer at bus to req low = 2 cycles. Best-case read (ok 1 cycle after req, dropped immediately) gives start to done = 6 cycles.
- Holds:
  - ad, nb_out and dt_out hold from start until the next start.
  - rdt_ holds until the next successful read.
- Reset mid-cycle: returns to IDLE immediately; req drops asynchronously; no done pulse.

Optional Feature:
- Macro: MEM_RETRY_EN.
- With the macro defined:
  - A pe answer on the first attempt reissues the same cycle once, after the answer drops (WAIT_DROP -> REQ). The timeout counter is reset for the new attempt.
  - perr is reported only if the second attempt also answers pe.
  - A retry counter bit resets at each start.
- Without the macro: pe ends the cycle immediately with perr.

Decomposition:
- Shared package mem_pkg:
  - state enum: IDLE, REQ, WAIT_DROP, FIN.
  - localparam widths: AW=16, DW=16, NBW=4.
  - Timeout counter width function clog2(TIMEOUT).
- Sub-module mem_timeout: loadable up-counter with clear, enable and terminal-count output. Instanced once.

Test Plan:
- Read: dad_=16'hEDCB, nb=3, bus answers ok after 3 cycles with dt_in=16'h1234, drops after 1 -> ad=16'h1234, r=1, w=0, nb_out=3; rdt_=16'hEDCB; one done pulse, no alarm/perr.
- Write: ddt_=16'h00FF, dad_=16'hFFFE -> ad=16'h0001, dt_out=16'hFF00, w=1; rdt_ unchanged; done after ok drop.
- Timeout (TIMEOUT=8), bus silent -> req high exactly 8 cycles; alarm and done pulse together; busy clears; a later ok is ignored.
- pe answer without MEM_RETRY_EN -> perr+done, rdt_ unchanged. With MEM_RETRY_EN: pe then ok -> req asserted twice, no perr, rdt_ updated.
- Start while busy (second start_rd 2 cycles after the first) -> ignored, exactly one bus cycle. start_rd and start_wr in the same cycle -> write cycle.
- rst_ low while in REQ -> req=0, rdt_=16'hFFFF, no done. Next start after release completes normally.
